// File: rtl/rx_pkt_stat_agg.sv
// rx_pkt_stat_agg: per-channel RX packet event counters with an atomic
// snapshot into a shadow bank and a two-stage read port on that bank.
// Optional feature macro: RX_PKT_STAT_STICKY_ERR_EN adds a per-channel sticky
// error summary (err_sticky). Without it err_sticky is tied to 0.
//
// Read handshake: rd_req is accepted unconditionally every cycle (no
// back-pressure); exactly one rd_ack pulse follows each accepted request two
// cycles later, unless rst is asserted in between, in which case the request
// is dropped. rd_data/rd_err are only meaningful while rd_ack=1 and are 0
// otherwise.
module rx_pkt_stat_agg #(
  parameter int NUM_CH = 4,
  parameter int CNT_WD = 48,
  localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] inc_rx_crc_ok,
  input  logic [NUM_CH-1:0] inc_rx_crc_err,
  input  logic [NUM_CH-1:0] inc_rx_sop,
  input  logic [NUM_CH-1:0] inc_rx_eop,
  input  logic [NUM_CH-1:0] inc_rx_pkt,
  input  logic [NUM_CH-1:0] inc_rx_miss_sop,
  input  logic [NUM_CH-1:0] inc_rx_miss_eop,
  input  logic              cfg_sat_en,
  input  logic              snap_req,
  input  logic              snap_clr,
  output logic [15:0]       snap_cnt,
  input  logic              rd_req,
  input  logic [CH_AW-1:0]  rd_ch,
  input  logic [2:0]        rd_evt,
  output logic              rd_ack,
  output logic [CNT_WD-1:0] rd_data,
  output logic              rd_err,
  output logic [NUM_CH-1:0] err_sticky
);

  localparam int NUM_EVT = 7;
  localparam logic [CNT_WD-1:0] CNT_ONE = {{(CNT_WD-1){1'b0}}, 1'b1};

  // Registered pulses, bit index = event index.
  logic [NUM_EVT-1:0] pulse_q [NUM_CH];
  logic [CNT_WD-1:0]  live    [NUM_CH][NUM_EVT];
  logic [CNT_WD-1:0]  shadow  [NUM_CH][NUM_EVT];

  logic               s1_vld;
  logic               s1_legal;
  logic [CNT_WD-1:0]  s1_data;
  logic               rd_legal;
  logic [CNT_WD-1:0]  rd_mux;

  // One increment step: saturate at all-ones or wrap, depending on mode.
  function automatic logic [CNT_WD-1:0] cnt_next(input logic [CNT_WD-1:0] cur,
                                                 input logic              inc,
                                                 input logic              sat);
    if (!inc) return cur;
    if (sat && (&cur)) return cur;
    return cur + CNT_ONE;
  endfunction

  // Input stage: register every pulse once before it reaches the counters.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        pulse_q[c] <= '0;
      end else begin
        pulse_q[c] <= {inc_rx_miss_eop[c], inc_rx_miss_sop[c], inc_rx_pkt[c],
                       inc_rx_eop[c], inc_rx_sop[c], inc_rx_crc_err[c],
                       inc_rx_crc_ok[c]};
      end
    end
  end

  // Live and shadow banks. A snapshot copies the pre-increment live value;
  // with clear, the live counter restarts from the pulse already in flight.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (rst) begin
          live[c][e]   <= '0;
          shadow[c][e] <= '0;
        end else begin
          if (snap_req) begin
            shadow[c][e] <= live[c][e];
          end
          if (snap_req && snap_clr) begin
            live[c][e] <= {{(CNT_WD-1){1'b0}}, pulse_q[c][e]};
          end else begin
            live[c][e] <= cnt_next(live[c][e], pulse_q[c][e], cfg_sat_en);
          end
        end
      end
    end
  end

  // Snapshot counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cnt <= '0;
    end else if (snap_req) begin
      snap_cnt <= snap_cnt + 16'd1;
    end
  end

  // Address check and shadow mux; illegal addresses select 0.
  always_comb begin
    rd_legal = ({1'b0, rd_ch} < (CH_AW+1)'(NUM_CH)) && (rd_evt < 3'd7);
    rd_mux   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (rd_ch == CH_AW'(c) && rd_evt == 3'(e)) begin
          rd_mux = shadow[c][e];
        end
      end
    end
  end

  // Read stage 1: capture request, legality and mux output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_legal <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_vld   <= rd_req;
      s1_legal <= rd_legal;
      s1_data  <= rd_mux;
    end
  end

  // Read stage 2: outputs, held at 0 whenever there is no acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack  <= 1'b0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      rd_ack  <= s1_vld;
      rd_data <= (s1_vld && s1_legal) ? s1_data : '0;
      rd_err  <= s1_vld && !s1_legal;
    end
  end

`ifdef RX_PKT_STAT_STICKY_ERR_EN
  logic [NUM_CH-1:0] sticky_q;

  // Sticky error summary: crc_err, miss_sop or miss_eop sets; a clearing
  // snapshot clears; a coincident set wins.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        sticky_q[c] <= 1'b0;
      end else if (pulse_q[c][1] || pulse_q[c][5] || pulse_q[c][6]) begin
        sticky_q[c] <= 1'b1;
      end else if (snap_req && snap_clr) begin
        sticky_q[c] <= 1'b0;
      end
    end
  end

  assign err_sticky = sticky_q;
`else
  assign err_sticky = '0;
`endif

endmodule

// File: tb/tb_rx_pkt_stat_agg.sv
// Testbench for rx_pkt_stat_agg: directed scenarios, a behavioural model of
// counts per snapshot interval, and a per-cycle compare of all outputs.
module tb_rx_pkt_stat_agg;

  localparam int NUM_CH  = 5;
  localparam int CNT_WD  = 16;
  localparam int CH_AW   = 3;
  localparam int NUM_EVT = 7;
  localparam longint CMAX = 65535;
`ifdef RX_PKT_STAT_STICKY_ERR_EN
  localparam logic [NUM_CH-1:0] STICKY3 = 5'b01000;
`else
  localparam logic [NUM_CH-1:0] STICKY3 = 5'b00000;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] inc [NUM_EVT];
  logic              cfg_sat_en;
  logic              snap_req;
  logic              snap_clr;
  logic [15:0]       snap_cnt;
  logic              rd_req;
  logic [CH_AW-1:0]  rd_ch;
  logic [2:0]        rd_evt;
  logic              rd_ack;
  logic [CNT_WD-1:0] rd_data;
  logic              rd_err;
  logic [NUM_CH-1:0] err_sticky;

  always #5 clk = ~clk;

  rx_pkt_stat_agg #(.NUM_CH(NUM_CH), .CNT_WD(CNT_WD)) dut (
    .clk(clk), .rst(rst),
    .inc_rx_crc_ok(inc[0]), .inc_rx_crc_err(inc[1]), .inc_rx_sop(inc[2]),
    .inc_rx_eop(inc[3]), .inc_rx_pkt(inc[4]), .inc_rx_miss_sop(inc[5]),
    .inc_rx_miss_eop(inc[6]),
    .cfg_sat_en(cfg_sat_en), .snap_req(snap_req), .snap_clr(snap_clr),
    .snap_cnt(snap_cnt), .rd_req(rd_req), .rd_ch(rd_ch), .rd_evt(rd_evt),
    .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err),
    .err_sticky(err_sticky)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Literal expectation attached to the next read request.
  bit     rd_lit;
  longint rd_lit_data;
  bit     rd_lit_err;

  // ---------------- model ----------------
  typedef struct {
    int     due;
    longint data;
    bit     err;
    bit     lit;
    longint ldata;
    bit     lerr;
  } rd_t;
  rd_t exp_q[$];

  int                cyc = 0;
  longint            live_m [NUM_CH][NUM_EVT];
  longint            shad_m [NUM_CH][NUM_EVT];
  logic [NUM_CH-1:0] flight_m [NUM_EVT];   // pulses seen last cycle, not yet counted
  int                snaps_m;
  logic [NUM_CH-1:0] sticky_m;

  // Model: a pulse counts two cycles after it is driven; a snapshot freezes the
  // counts present at that cycle; a clearing snapshot starts a new interval
  // that already contains the pulse driven one cycle earlier.
  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++)
        for (int e = 0; e < NUM_EVT; e++) begin
          live_m[c][e] = 0;
          shad_m[c][e] = 0;
        end
      for (int e = 0; e < NUM_EVT; e++) flight_m[e] = '0;
      snaps_m  = 0;
      sticky_m = '0;
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    end else begin
      if (rd_req) begin
        rd_t r;
        bit  legal;
        legal   = (int'(rd_ch) < NUM_CH) && (int'(rd_evt) < NUM_EVT);
        r.due   = cyc + 2;
        r.data  = legal ? shad_m[rd_ch][rd_evt] : 0;
        r.err   = !legal;
        r.lit   = rd_lit;
        r.ldata = rd_lit_data;
        r.lerr  = rd_lit_err;
        exp_q.push_back(r);
      end
      for (int c = 0; c < NUM_CH; c++)
        for (int e = 0; e < NUM_EVT; e++) begin
          bit landing;
          landing = flight_m[e][c];
          if (snap_req) shad_m[c][e] = live_m[c][e];
          if (snap_req && snap_clr) live_m[c][e] = landing ? 1 : 0;
          else if (landing) begin
            if (live_m[c][e] == CMAX) live_m[c][e] = cfg_sat_en ? CMAX : 0;
            else live_m[c][e] = live_m[c][e] + 1;
          end
        end
      if (snap_req && snap_clr) sticky_m = '0;
      sticky_m = sticky_m | flight_m[1] | flight_m[5] | flight_m[6];
      if (snap_req) snaps_m = (snaps_m + 1) % 65536;
      for (int e = 0; e < NUM_EVT; e++) flight_m[e] = inc[e];
    end
    cyc++;
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic              e_ack;
      longint            e_data;
      bit                e_err;
      logic [NUM_CH-1:0] e_sticky;
      e_ack  = 1'b0;
      e_data = 0;
      e_err  = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        rd_t r;
        r      = exp_q.pop_front();
        e_ack  = 1'b1;
        e_data = r.data;
        e_err  = r.err;
        if (r.lit) begin
          chk("rd_data_literal", 64'(rd_data), r.ldata);
          chk("rd_err_literal", 64'(rd_err), 64'(r.lerr));
        end
      end
`ifdef RX_PKT_STAT_STICKY_ERR_EN
      e_sticky = sticky_m;
`else
      e_sticky = '0;
`endif
      chk("rd_ack", 64'(rd_ack), 64'(e_ack));
      chk("rd_data", 64'(rd_data), e_data);
      chk("rd_err", 64'(rd_err), 64'(e_err));
      chk("snap_cnt", 64'(snap_cnt), 64'(snaps_m));
      chk("err_sticky", 64'(err_sticky), 64'(e_sticky));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    for (int e = 0; e < NUM_EVT; e++) inc[e] = '0;
    snap_req = 1'b0;
    snap_clr = 1'b0;
    rd_req   = 1'b0;
    rd_lit   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int e, input int c);
    inc[e][c] = 1'b1;
    tick();
  endtask

  task automatic snap(input bit clr);
    snap_req = 1'b1;
    snap_clr = clr;
    tick();
  endtask

  task automatic rd(input int ch, input int evt, input longint ldata, input bit lerr);
    rd_req      = 1'b1;
    rd_ch       = CH_AW'(ch);
    rd_evt      = 3'(evt);
    rd_lit      = 1'b1;
    rd_lit_data = ldata;
    rd_lit_err  = lerr;
    tick();
  endtask

  // Runaway guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int e = 0; e < NUM_EVT; e++) inc[e] = '0;
    cfg_sat_en = 1'b1;
    snap_req = 1'b0; snap_clr = 1'b0;
    rd_req = 1'b0; rd_ch = '0; rd_evt = '0;
    rd_lit = 1'b0; rd_lit_data = 0; rd_lit_err = 1'b0;
    idle(2);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("snap_cnt_after_reset", 64'(snap_cnt), 64'd0);
    chk("sticky_after_reset", 64'(err_sticky), 64'd0);
    rd(0, 0, 0, 1'b0);
    idle(2);

    // Count and read: 5 pkt pulses on channel 2.
    for (int i = 0; i < 5; i++) pulse(4, 2);
    idle(2);
    snap(1'b0);
    rd(2, 4, 5, 1'b0);
    idle(2);
    @(negedge clk);
    chk("snap_cnt_one", 64'(snap_cnt), 64'd1);

    // Clearing snapshot with pulses at M-1 and M.
    for (int i = 0; i < 3; i++) pulse(2, 0);
    tick();
    inc[2][0] = 1'b1;
    tick();
    inc[2][0] = 1'b1;
    snap_req = 1'b1;
    snap_clr = 1'b1;
    tick();
    rd(0, 2, 3, 1'b0);
    idle(2);
    snap(1'b1);
    rd(0, 2, 2, 1'b0);
    idle(2);

    // Back-to-back reads: channel 1 event e holds e+1.
    for (int e = 0; e < NUM_EVT; e++)
      for (int k = 0; k <= e; k++) pulse(e, 1);
    idle(2);
    snap(1'b0);
    for (int e = 0; e < NUM_EVT; e++) rd(1, e, e + 1, 1'b0);
    idle(3);

    // Illegal addresses.
    rd(5, 0, 0, 1'b1);
    rd(7, 6, 0, 1'b1);
    rd(0, 7, 0, 1'b1);
    rd(3, 7, 0, 1'b1);
    idle(3);

    // Saturation vs wrap on 16-bit counters.
    snap(1'b1);
    idle(2);
    repeat (65535) begin
      inc[0][0] = 1'b1;
      inc[0][1] = 1'b1;
      tick();
    end
    idle(2);
    cfg_sat_en = 1'b1;
    pulse(0, 0);
    idle(3);
    cfg_sat_en = 1'b0;
    pulse(0, 1);
    idle(3);
    snap(1'b0);
    rd(0, 0, 65535, 1'b0);
    rd(1, 0, 0, 1'b0);
    idle(3);
    cfg_sat_en = 1'b1;

    // Reset with reads in flight, then sticky set/clear.
    rd_req = 1'b1; rd_ch = 3'd0; rd_evt = 3'd0;
    inc[1][3] = 1'b1;
    tick();
    rd_req = 1'b1; rd_ch = 3'd1; rd_evt = 3'd0;
    rst = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("sticky_after_mid_reset", 64'(err_sticky), 64'd0);
    chk("snap_cnt_after_mid_reset", 64'(snap_cnt), 64'd0);
    rd(2, 4, 0, 1'b0);
    rd(0, 2, 0, 1'b0);
    rd(1, 6, 0, 1'b0);
    idle(2);
    pulse(1, 3);
    idle(2);
    @(negedge clk);
    chk("sticky_set_ch3", 64'(err_sticky), 64'(STICKY3));
    snap(1'b1);
    @(negedge clk);
    chk("sticky_cleared", 64'(err_sticky), 64'd0);
    rd(3, 1, 1, 1'b0);
    idle(4);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_pkt_stat_agg.md
# rx_pkt_stat_agg

Multi-channel RX packet statistics aggregator. It sits directly behind the per-channel RX packet checkers of the packet client and accumulates their per-event increment pulses into per-channel, per-event counters. Counters can be frozen into a readable shadow bank by an atomic snapshot, optionally cleared at the same time. A pipelined read port serves the shadow bank to the CSR layer.

## Interface
Parameters:
- NUM_CH, 4: number of checker channels (1..32).
- CNT_WD, 48: counter width in bits (16..64).
- CH_AW, $clog2(NUM_CH) with a minimum of 1: channel address width. Derived; do not override.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: synchronous, active-high reset.
- inc_rx_crc_ok, inc_rx_crc_err, inc_rx_sop, inc_rx_eop, inc_rx_pkt, inc_rx_miss_sop, inc_rx_miss_eop: in, NUM_CH each. One-cycle increment pulses. Event index is 0..6 in the order listed.
- cfg_sat_en, in, 1: 1 = counters saturate, 0 = counters wrap.
- snap_req, in, 1: single-cycle snapshot request.
- snap_clr, in, 1: qualifies snap_req; when set, live counters are cleared on the snapshot.
- snap_cnt, out, 16: number of snapshots taken; wraps.
- rd_req, in, 1: read request; one may be issued every cycle.
- rd_ch, in, CH_AW: channel to read.
- rd_evt, in, 3: event index to read.
- rd_ack, out, 1: read data valid.
- rd_data, out, CNT_WD: shadow counter value.
- rd_err, out, 1: the address was illegal.
- err_sticky, out, NUM_CH: per-channel error summary. Only present when the Configuration feature is enabled.

## Operation
- Input stage: all 7×NUM_CH pulses are registered once before they reach the counters.
- Live bank: NUM_CH×7 counters of CNT_WD bits each. Each counter adds its registered pulse every cycle.
  - cfg_sat_en=1: a counter at all-ones holds.
  - cfg_sat_en=0: a counter wraps from all-ones to 0.
- Snapshot (snap_req=1 in cycle M):
  - Every shadow counter loads its live value as it stands in cycle M, before cycle M's increment.
  - snap_clr=1: every live counter loads its registered pulse (0 or 1), so an increment in flight is never lost.
  - snap_clr=0: live counters continue counting normally.
  - snap_cnt increments by 1.
- Read pipeline:
  - Stage 1 registers rd_ch, rd_evt, the legality check and the shadow mux output.
  - Stage 2 drives rd_ack, rd_data and rd_err.
  - rd_req in the same cycle as snap_req returns the pre-snapshot shadow value.
- Illegal read: rd_ch ≥ NUM_CH or rd_evt > 6 gives rd_data=0 and rd_err=1, with rd_ack still asserted.
- When rd_ack=0, rd_data and rd_err are held at 0.
- Reset: live counters, shadow counters, input registers, snap_cnt, rd_ack, rd_data, rd_err and err_sticky are all 0.
- Reset mid-read: in-flight reads are discarded and no rd_ack is issued for them.

## Timing
- Pulse at cycle N is registered at N+1 and is visible in the live counter from N+2.
- A snapshot in cycle M captures pulses up to M-2. A pulse at M-1 lands in the new interval.
- Read latency is 2: rd_req at N gives rd_ack at N+2. Throughput is 1 read per cycle.
- Snapshot latency: the shadow value is readable by an rd_req issued at M+1 or later.
- There is no back-pressure. snap_req in consecutive cycles takes consecutive snapshots.
- Simultaneous pulses on different channels or events are all counted. There is no arbitration.

## Configuration
- Macro: RX_PKT_STAT_STICKY_ERR_EN.
- Defined:
  - err_sticky[c] sets one cycle after any registered crc_err, miss_sop or miss_eop pulse on channel c.
  - It clears on snap_req with snap_clr=1.
  - If set and clear coincide, set wins.
- Undefined: err_sticky is driven 0. The error logic is not instantiated.

## Test plan
- Count and read: NUM_CH=4, 5 pulses of inc_rx_pkt[2], then snap_req with snap_clr=0, then rd_ch=2, rd_evt=4 → rd_ack 2 cycles later with rd_data=5, rd_err=0, snap_cnt=1.
- Clear with coincident pulse: inc_rx_sop[0] at M-1 and at M, snap_req with snap_clr=1 at M (after 3 earlier pulses) → shadow=3. A second snapshot with no further pulses → shadow=2.
- Saturation vs wrap: CNT_WD=16, preload by 65535 pulses, one more pulse, cfg_sat_en=1 → read 65535. Repeat with cfg_sat_en=0 → read 0.
- Back-to-back reads: rd_req on 7 consecutive cycles covering events 0..6 of channel 1 → 7 consecutive rd_ack with matching data in order.
- Illegal address: rd_ch=5 with NUM_CH=4, and separately rd_evt=7 → rd_ack=1, rd_err=1, rd_data=0.
- Reset mid-operation plus sticky (macro defined): 2 reads in flight, then inc_rx_crc_err[3] pulse, then rst → no rd_ack, all counters read 0 afterwards, err_sticky=0. A crc_err pulse after reset sets err_sticky[3]. snap_req with snap_clr=1 clears it.
